// File: rtl/lsp0_scalar_dequant.sv
// LSP0 scalar dequantiser: rebuilds the codebook frequency (Hz) from a 4-bit
// index and converts it to radians with an 11-step bit-serial shift-add
// multiply. Both results are presented as unsigned 1-15-16 fixed-point words.
module lsp0_scalar_dequant #(
    parameter int unsigned N       = 32,
    parameter int unsigned CB_BASE = 500,
    parameter int unsigned CB_STEP = 50,
    parameter logic [21:0] K_RAD   = 22'h3378CB,
    parameter int unsigned HZ_BITS = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   index,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] lsp_hz,
    output logic [N-1:0] lsp_rad,
    output logic         busy
);

    localparam int unsigned ACC_W = 33;
    localparam int unsigned CNT_W = $clog2(HZ_BITS);
    localparam logic [HZ_BITS-1:0] BASE_W = HZ_BITS'(CB_BASE);
    localparam logic [HZ_BITS-1:0] STEP_W = HZ_BITS'(CB_STEP);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(HZ_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [HZ_BITS-1:0] hz_q, hz_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       hz_out_q, hz_out_d;
    logic [N-1:0]       rad_out_q, rad_out_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign lsp_hz    = hz_out_q;
    assign lsp_rad   = rad_out_q;

    // State register and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hz_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hz_out_q  <= '0;
            rad_out_q <= '0;
        end else begin
            state_q   <= state_d;
            hz_q      <= hz_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hz_out_q  <= hz_out_d;
            rad_out_q <= rad_out_d;
        end
    end

    // Next-state logic; one multiplier bit is consumed per MULT cycle and the
    // final partial sum is captured into the outputs on the last bit.
    always_comb begin
        state_d   = state_q;
        hz_d      = hz_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hz_out_d  = hz_out_q;
        rad_out_d = rad_out_q;
        addend    = hz_q[cnt_q] ? (ACC_W'(K_RAD) << cnt_q) : '0;
        acc_sum   = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hz_d    = BASE_W + STEP_W * HZ_BITS'(index);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    hz_out_d  = N'({hz_q, 16'b0});
                    rad_out_d = N'(acc_sum[31:16]);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsp0_scalar_dequant.sv
// Directed bench for lsp0_scalar_dequant: reset values, latency, back-pressure,
// full index sweep, mid-operation reset and busy-time input rejection.
module tb_lsp0_scalar_dequant;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  index;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lsp_hz;
    logic [31:0] lsp_rad;
    logic        busy;

    int checks;
    int errors;

    lsp0_scalar_dequant #(
        .N       (32),
        .CB_BASE (500),
        .CB_STEP (50),
        .K_RAD   (22'h3378CB),
        .HZ_BITS (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .index     (index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lsp_hz    (lsp_hz),
        .lsp_rad   (lsp_rad),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one index for a single accepting edge; returns at the negedge after it.
    task automatic send(input logic [3:0] idx);
        @(negedge clk);
        in_valid = 1'b1;
        index    = idx;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count negedges until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          busy_n;
        int          cyc;
        int          rises;
        logic        seen;
        logic        stable;
        logic        prev_v;
        logic [63:0] hz_e;
        logic [63:0] rad_e;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        index     = 4'd0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_hz",        64'(lsp_hz),    64'd0);
        chk("rst_rad",       64'(lsp_rad),   64'd0);
        rst = 1'b1;

        // index 0: latency and first result
        send(4'd0);
        chk("i0_in_ready_drop", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("i0_latency", 64'(lat), 64'd11);
        chk("i0_hz",  64'(lsp_hz),  64'h01F40000);
        chk("i0_rad", 64'(lsp_rad), 64'h00006487);
        out_ready = 1'b1;
        @(negedge clk);
        chk("i0_valid_fall", 64'(out_valid), 64'd0);
        chk("i0_ready_back", 64'(in_ready),  64'd1);

        // index 15 with out_ready already high
        send(4'd15);
        wait_valid(lat);
        chk("i15_latency", 64'(lat), 64'd11);
        chk("i15_hz",  64'(lsp_hz),  64'h04E20000);
        chk("i15_rad", 64'(lsp_rad), 64'h0000FB53);
        @(negedge clk);
        chk("i15_done", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // index 8 held in DONE for 20 cycles
        send(4'd8);
        wait_valid(lat);
        chk("i8_latency", 64'(lat), 64'd11);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (lsp_hz !== 32'h03840000 || lsp_rad !== 32'h0000B4F4 ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("i8_hold_stable", 64'(stable), 64'd1);
        chk("i8_hz",  64'(lsp_hz),  64'h03840000);
        chk("i8_rad", 64'(lsp_rad), 64'h0000B4F4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("i8_valid_fall", 64'(out_valid), 64'd0);
        chk("i8_ready_back", 64'(in_ready),  64'd1);

        // Sweep all indices with in_valid and out_ready held high
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            index  = 4'(i);
            busy_n = 0;
            cyc    = 0;
            seen   = 1'b0;
            hz_e   = 64'(500 + 50 * i);
            rad_e  = (hz_e * 64'd3373259) >> 16;
            do begin
                @(negedge clk);
                cyc++;
                if (busy) busy_n++;
                if (out_valid && !seen) begin
                    seen = 1'b1;
                    chk($sformatf("sweep_hz_%0d", i),  64'(lsp_hz),  hz_e << 16);
                    chk($sformatf("sweep_rad_%0d", i), 64'(lsp_rad), rad_e);
                end
            end while (!in_ready && cyc < 40);
            chk($sformatf("sweep_busy_cycles_%0d", i), 64'(busy_n), 64'd12);
            chk($sformatf("sweep_seen_%0d", i), 64'(seen), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset during MULT at count 5
        send(4'd12);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_busy",      64'(busy),      64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        chk("mrst_hz",        64'(lsp_hz),    64'd0);
        chk("mrst_rad",       64'(lsp_rad),   64'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_no_output", 64'(seen), 64'd0);
        send(4'd3);
        wait_valid(lat);
        chk("i3_latency", 64'(lat), 64'd11);
        chk("i3_hz",  64'(lsp_hz),  64'h028A0000);
        chk("i3_rad", 64'(lsp_rad), 64'd33456);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // in_valid with another index while busy must be ignored
        send(4'd2);
        @(negedge clk);
        in_valid = 1'b1;
        index    = 4'd9;
        rises    = 0;
        prev_v   = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid && !prev_v) rises++;
            prev_v = out_valid;
        end
        chk("ign_hz",  64'(lsp_hz),  64'h02580000);
        chk("ign_rad", 64'(lsp_rad), 64'h000078A3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid && !prev_v) rises++;
            prev_v = out_valid;
        end
        chk("ign_single_result", 64'(rises), 64'd1);
        chk("ign_idle_end",      64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
